// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences lw/sw/R-type/beq/addi/j with a memory-ready stall.
// Optional bne support is enabled by defining MIPS_BNE_EN.
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               Illegal,
  output logic [STATE_W-1:0] DbgState
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state;
  state_t     state_next;
  logic [1:0] alu_op;
  logic       pc_write;
  logic       branch;
  logic       branch_taken;
  logic       funct_ok;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_next;
  end

  always_comb begin
    funct_ok = 1'b0;
    case (Funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
      default:                                               funct_ok = 1'b0;
    endcase
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_next = state;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    Illegal    = 1'b0;
    alu_op     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;

    // Outputs are decoded from state; holding them at defaults while reset is low blocks any write.
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          ALUSrcB    = 2'b01;
          IRWrite    = MemReady;
          pc_write   = MemReady;
          state_next = MemReady ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (Op)
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_RTYPE: begin
              if (funct_ok) begin
                state_next = S_EXECUTE;
              end else begin
                state_next = S_FETCH;
                Illegal    = 1'b1;
              end
            end
            OP_BEQ:  state_next = S_BRANCH;
`ifdef MIPS_BNE_EN
            OP_BNE:  state_next = S_BRANCH;
`endif
            OP_ADDI: state_next = S_ADDIEXEC;
            OP_J:    state_next = S_JUMP;
            default: begin
              state_next = S_FETCH;
              Illegal    = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          if (Op == OP_SW)      state_next = S_MEMWR;
          else if (Op == OP_LW) state_next = S_MEMRD;
          else                  state_next = S_FETCH;
        end
        S_MEMRD: begin
          IorD       = 1'b1;
          state_next = MemReady ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMWR: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          state_next = MemReady ? S_FETCH : S_MEMWR;
        end
        S_EXECUTE: begin
          ALUSrcA    = 1'b1;
          alu_op     = 2'b10;
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          alu_op     = 2'b01;
          PCSrc      = 2'b01;
          branch     = 1'b1;
          state_next = S_FETCH;
        end
        S_ADDIEXEC: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          state_next = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegWrite   = 1'b1;
          state_next = S_FETCH;
        end
        S_JUMP: begin
          PCSrc      = 2'b10;
          pc_write   = 1'b1;
          state_next = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

  always_comb begin
    ALUControl = 3'b010;
    case (alu_op)
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (Funct)
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

`ifdef MIPS_BNE_EN
  assign branch_taken = Zero ^ (Op == OP_BNE);
`else
  assign branch_taken = Zero;
`endif

  assign PCEn     = pc_write | (branch & branch_taken);
  assign DbgState = STATE_W'(state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed cases, a mid-instruction reset,
// then randomized instructions and stalls checked cycle by cycle against an instruction-level model.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
`ifdef MIPS_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif
  // {state, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, Illegal}
  localparam logic [19:0] RESET_VEC = {4'd0, 7'b0, 2'b00, 3'b010, 2'b00, 2'b00};

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] Op, Funct;
  logic       Zero, MemReady;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] DbgState;
  logic [19:0] outv;

  int n_checks = 0;
  int n_pass   = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal), .DbgState(DbgState)
  );

  always #5 clk = ~clk;

  assign outv = {DbgState, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, ALUControl, PCSrc, PCEn, Illegal};

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
  endtask

  function automatic bit funct_valid(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] f);
    return (op inside {LW, SW, BEQ, ADDI, JMP}) || (op == RT && funct_valid(f)) ||
           (BNE_EN && op == BNE);
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for one cycle, straight from the per-state control table.
  function automatic logic [19:0] exp_out(input int st, input bit mr, input logic [5:0] op,
                                          input logic [5:0] f, input bit zero);
    logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, pcen = 0, ill = 0;
    logic [1:0] sb = 2'b00, pcs = 2'b00;
    logic [2:0] alu = 3'b010;
    case (st)
      0:  begin sb = 2'b01; irw = mr; pcen = mr; end
      1:  begin sb = 2'b11; ill = !legal(op, f); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; alu = rtype_alu(f); end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; alu = 3'b110; pcs = 2'b01; pcen = zero ^ (BNE_EN && op == BNE); end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {4'(st), iord, mw, irw, rd, m2r, rw, sa, sb, alu, pcs, pcen, ill};
  endfunction

  // Called just after a rising edge with the DUT in FETCH; runs one instruction to completion.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input bit zero,
                           input int fst, input int mst, input string name);
    int st_q[$];
    bit mr_q[$];
    for (int i = 0; i < fst; i++) begin st_q.push_back(0); mr_q.push_back(0); end
    st_q.push_back(0); mr_q.push_back(1);
    st_q.push_back(1); mr_q.push_back(1'($urandom_range(0, 1)));
    if (legal(op, f)) begin
      case (op)
        LW: begin
          st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
          for (int i = 0; i < mst; i++) begin st_q.push_back(3); mr_q.push_back(0); end
          st_q.push_back(3); mr_q.push_back(1);
          st_q.push_back(4); mr_q.push_back(1'($urandom_range(0, 1)));
        end
        SW: begin
          st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
          for (int i = 0; i < mst; i++) begin st_q.push_back(5); mr_q.push_back(0); end
          st_q.push_back(5); mr_q.push_back(1);
        end
        RT: begin
          st_q.push_back(6); mr_q.push_back(1'($urandom_range(0, 1)));
          st_q.push_back(7); mr_q.push_back(1'($urandom_range(0, 1)));
        end
        ADDI: begin
          st_q.push_back(9);  mr_q.push_back(1'($urandom_range(0, 1)));
          st_q.push_back(10); mr_q.push_back(1'($urandom_range(0, 1)));
        end
        JMP: begin st_q.push_back(11); mr_q.push_back(1'($urandom_range(0, 1))); end
        default: begin st_q.push_back(8); mr_q.push_back(1'($urandom_range(0, 1))); end
      endcase
    end
    Op = op; Funct = f; Zero = zero;
    foreach (st_q[i]) begin
      MemReady = mr_q[i];
      @(negedge clk);
      check($sformatf("%s_c%0d", name, i), outv, exp_out(st_q[i], mr_q[i], op, f, zero));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [5:0] vf [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset_n = 1'b0; Op = '0; Funct = '0; Zero = 1'b0; MemReady = 1'b1;
    #1 check("reset_hold", outv, RESET_VEC);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    run_instr(LW,   6'b000000,  1'b0, 0, 0, "lw");
    run_instr(RT,   6'b101010,  1'b0, 0, 0, "slt");
    run_instr(RT,   6'b100111,  1'b0, 0, 0, "bad_funct");
    run_instr(BEQ,  6'b000000,  1'b1, 0, 0, "beq_taken");
    run_instr(BEQ,  6'b000000,  1'b0, 0, 0, "beq_not");
    run_instr(SW,   6'b000000,  1'b0, 3, 3, "sw_stall");
    run_instr(ADDI, 6'b000000,  1'b0, 1, 0, "addi");
    run_instr(JMP,  6'b000000,  1'b0, 0, 0, "jump");
    run_instr(BNE,  6'b000000,  1'b0, 0, 0, "bne_z0");
    run_instr(BNE,  6'b000000,  1'b1, 0, 0, "bne_z1");

    // Abort an lw while it waits in MEMRD.
    Op = LW; Funct = '0; Zero = 1'b0; MemReady = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    MemReady = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_memrd", outv, exp_out(3, 0, LW, 6'b0, 0));
    #2 reset_n = 1'b0; MemReady = 1'b1;
    #1 check("mid_reset", outv, RESET_VEC);
    @(posedge clk); #1;
    check("reset_no_advance", outv, RESET_VEC);
    reset_n = 1'b1;
    run_instr(LW, 6'b000000, 1'b0, 0, 0, "post_reset");

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, f;
      int sel = $urandom_range(0, 8);
      f = 6'($urandom_range(0, 63));
      case (sel)
        0: op = LW;
        1: op = SW;
        2: begin op = RT; f = vf[$urandom_range(0, 4)]; end
        3: op = RT;
        4: op = BEQ;
        5: op = ADDI;
        6: op = JMP;
        7: op = BNE;
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, f, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                $sformatf("rnd%0d_op%02h", n, op));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle MIPS control unit. It drives the ALU's control interface (SrcA/SrcB select and ALUControl) and consumes the ALU's Zero flag. It also generates all datapath and memory enables for lw, sw, R-type (add/sub/and/or/slt), beq, addi and j. A memory-ready handshake stalls fetch and data access.

Parameters:
STATE_W, 4, width of DbgState output (must be >= 4)

Ports:
clk  in  1  single system clock, rising edge
reset_n  in  1  asynchronous active-low reset
Op  in  6  instruction[31:26] from instruction register
Funct  in  6  instruction[5:0]
Zero  in  1  ALU zero flag
MemReady  in  1  memory handshake: access completes this cycle
IorD  out  1  0 = PC addresses memory, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
RegDst  out  1  0 = rt, 1 = rd
MemtoReg  out  1  0 = ALUOut, 1 = Data register
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
ALUControl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
PCEn  out  1  PC register enable
Illegal  out  1  unsupported opcode/funct detected in DECODE
DbgState  out  STATE_W  current state encoding

Behaviour:
- States (4-bit encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11.
- Reset: async on reset_n low. State = FETCH. All outputs are combinational from state and inputs. Asserting reset mid-instruction aborts it; no writes occur during reset.
- Defaults in every state: all enables 0, selects 0, ALUOp = 00.
- FETCH: ALUSrcA 0, ALUSrcB 01, ALUOp 00, PCSrc 00, IorD 0. IRWrite and PCWrite = MemReady. Stay in FETCH until MemReady = 1, then go to DECODE.
- DECODE: ALUSrcA 0, ALUSrcB 11, ALUOp 00. Next state by opcode:
  - lw 100011 or sw 101011 -> MEMADR
  - R-type 000000 with supported funct -> EXECUTE
  - beq 000100 -> BRANCH
  - addi 001000 -> ADDIEXEC
  - j 000010 -> JUMP
  - anything else -> FETCH, with Illegal = 1 for this cycle only
- MEMADR: ALUSrcA 1, ALUSrcB 10, ALUOp 00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: IorD 1. Hold until MemReady, then MEMWB.
- MEMWB: RegDst 0, MemtoReg 1, RegWrite 1. Next FETCH.
- MEMWR: IorD 1, MemWrite 1, held every cycle until MemReady. Then FETCH.
- EXECUTE: ALUSrcA 1, ALUSrcB 00, ALUOp 10. Next ALUWB.
- ALUWB: RegDst 1, MemtoReg 0, RegWrite 1. Next FETCH.
- BRANCH: ALUSrcA 1, ALUSrcB 00, ALUOp 01, PCSrc 01, Branch 1. Next FETCH.
- ADDIEXEC: ALUSrcA 1, ALUSrcB 10, ALUOp 00. Next ADDIWB.
- ADDIWB: RegDst 0, MemtoReg 0, RegWrite 1. Next FETCH.
- JUMP: PCSrc 10, PCWrite 1. Next FETCH.
- ALU decode:
  - ALUOp 00 -> 010; ALUOp 01 -> 110.
  - ALUOp 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct -> 010 (unreachable, since DECODE filters it).
- PCEn = PCWrite | (Branch & BranchTaken), where BranchTaken = Zero.
- Latencies in cycles, with MemReady tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each MemReady = 0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Unused state encodings (12-15) -> FETCH on the next clock.

Optional Feature:
MIPS_BNE_EN
- Defined: opcode 000101 (bne) is legal and DECODE sends it to BRANCH. In BRANCH, BranchTaken = Zero XOR (Op == 000101).
- Undefined: 000101 is illegal (Illegal pulse, return to FETCH) and BranchTaken = Zero.

Test Plan:
- reset_n low mid-MEMRD (DbgState 3) -> DbgState = 0 immediately, all enables 0. Release, MemReady = 1 -> IRWrite = PCEn = 1 and ALUSrcB = 01 in the first cycle.
- lw (Op 100011), MemReady = 1 -> state sequence 0,1,2,3,4. RegWrite = 1 and MemtoReg = 1 only in state 4.
- R-type Funct 101010 -> ALUControl = 111 in EXECUTE. Funct 100111 -> Illegal = 1 in DECODE, then FETCH, no RegWrite.
- beq with Zero = 1 -> PCEn = 1, PCSrc = 01, ALUControl = 110 in BRANCH. With Zero = 0 -> PCEn = 0.
- sw with MemReady low for 3 cycles in MEMWR -> MemWrite held 4 cycles, then FETCH. Same stall in FETCH -> IRWrite = 0 until MemReady.
- With MIPS_BNE_EN, Op 000101, Zero = 0 -> PCEn = 1. Without the macro -> Illegal = 1, no branch.
